// File: rtl/fp_posit_mul_vec.sv
// Multi-lane FP x posit multiplier: broadcast activation, bit-serial posit weights per lane,
// unnormalised sign/scale/product per lane with valid/ready output handshake.

module fp_posit_mul_vec_lane #(
  parameter int MAN_WIDTH = 10,
  parameter int MAX_W     = 16,
  parameter int MAX_ES    = 2,
  parameter int PF        = 13,
  parameter int PW        = 25,
  parameter int SW        = 13,
  parameter int NW        = 5,
  parameter int EW        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic                 first_beat,
  input  logic                 w_bit,
  input  logic                 dec_en,
  input  logic                 mul_en,
  input  logic [NW-1:0]        n,
  input  logic [EW-1:0]        es,
  input  logic                 a_zero,
  input  logic                 a_nar,
  input  logic                 a_sign,
  input  logic signed [SW-1:0] a_exp,
  input  logic [MAN_WIDTH-1:0] a_frac,
  output logic                 sign_out,
  output logic [SW-1:0]        exp_out,
  output logic [PW-1:0]        mant_out,
  output logic                 zero_out,
  output logic                 nar_out
);
  logic [MAX_W-1:0] word;
  logic [MAX_W-1:0] aligned, mag, rem, remf;
  logic [NW-1:0]    run;
  logic             done, rb;
  logic signed [SW-1:0] k, scale_c;
  logic [MAX_ES-1:0] e_v;
  logic [PF-1:0]     frac_c;
  logic p_zero_c, p_nar_c, p_sign_c;

  logic p_zero, p_nar, p_sign;
  logic signed [SW-1:0] p_scale;
  logic [PF-1:0] p_frac;
  logic nar_c, zero_c;

  always_ff @(posedge clk or negedge rst)
    if (!rst) word <= '0;
    else if (shift_en) word <= first_beat ? {{(MAX_W-1){1'b0}}, w_bit} : {word[MAX_W-2:0], w_bit};

  // Word is left-aligned so padding below the n valid bits is zero and cannot
  // extend a regime run of zeros (a nonzero magnitude always has a 1 inside n).
  always_comb begin
    aligned  = word << (NW'(MAX_W) - n);
    p_zero_c = (aligned == '0);
    p_nar_c  = (aligned == {1'b1, {(MAX_W-1){1'b0}}});
    p_sign_c = aligned[MAX_W-1];
    mag      = p_sign_c ? (~aligned + 1'b1) : aligned;
    rb       = mag[MAX_W-2];
    run      = '0;
    done     = 1'b0;
    for (int i = MAX_W-2; i >= 0; i--) begin
      if (!done) begin
        if (mag[i] == rb) run = run + NW'(1);
        else              done = 1'b1;
      end
    end
    k       = rb ? (SW'(run) - SW'(1)) : (SW'(0) - SW'(run));
    rem     = mag << (run + NW'(2));
    e_v     = rem[MAX_W-1 -: MAX_ES] >> (EW'(MAX_ES) - es);
    remf    = rem << es;
    frac_c  = PF'(remf >> (MAX_W - PF));
    scale_c = (k <<< es) + SW'(e_v);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      p_zero <= 1'b0; p_nar <= 1'b0; p_sign <= 1'b0; p_scale <= '0; p_frac <= '0;
    end else if (dec_en) begin
      p_zero <= p_zero_c; p_nar <= p_nar_c; p_sign <= p_sign_c; p_scale <= scale_c; p_frac <= frac_c;
    end

  assign nar_c  = a_nar | p_nar;
  assign zero_c = ~nar_c & (a_zero | p_zero);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sign_out <= 1'b0; exp_out <= '0; mant_out <= '0; zero_out <= 1'b0; nar_out <= 1'b0;
    end else if (mul_en) begin
      zero_out <= zero_c;
      nar_out  <= nar_c;
      if (nar_c || zero_c) begin
        sign_out <= 1'b0; exp_out <= '0; mant_out <= '0;
      end else begin
        sign_out <= a_sign ^ p_sign;
        exp_out  <= a_exp + p_scale;
        mant_out <= PW'({1'b1, a_frac}) * PW'({1'b1, p_frac});
      end
    end
endmodule

module fp_posit_mul_vec #(
  parameter int ACT_WIDTH = 16,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int NUM_LANES = 4,
  parameter int MAX_W     = 16,
  parameter int MAX_ES    = 2,
  localparam int PF = MAX_W - 3,
  localparam int PW = MAN_WIDTH + PF + 2,
  localparam int SW = EXP_WIDTH + MAX_ES + $clog2(MAX_W) + 2,
  localparam int NW = $clog2(MAX_W + 1),
  localparam int EW = $clog2(MAX_ES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set,
  input  logic [NW-1:0]             precision,
  input  logic [EW-1:0]             es,
  input  logic [ACT_WIDTH-1:0]      act,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_LANES-1:0]      w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES-1:0]      sign_out,
  output logic [NUM_LANES*SW-1:0]   exp_out,
  output logic [NUM_LANES*PW-1:0]   mantissa_out,
  output logic [NUM_LANES-1:0]      zero_out,
  output logic [NUM_LANES-1:0]      nar_out
);
  localparam int BIAS = 2**(EXP_WIDTH-1) - 1;

  typedef enum logic [2:0] {IDLE, SHIFT, DECODE, MUL, HOLD} state_t;
  state_t state, state_nx;

  logic [NW-1:0]        n_q, cnt, cnt_nx;
  logic [EW-1:0]        es_q;
  logic [ACT_WIDTH-1:0] act_q;
  logic                 acc, last;

  assign acc    = in_valid & in_ready;
  assign cnt_nx = cnt + NW'(1);
  assign last   = (cnt_nx == n_q);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:   begin in_ready = 1'b1; if (in_valid) state_nx = SHIFT; end
      SHIFT:  begin in_ready = 1'b1; if (in_valid && last) state_nx = DECODE; end
      DECODE: state_nx = MUL;
      MUL:    state_nx = HOLD;
      HOLD:   begin out_valid = 1'b1; if (out_ready) state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      n_q <= NW'(MAX_W); es_q <= '0; cnt <= '0; act_q <= '0;
    end else begin
      if (state == IDLE && set) begin
        n_q  <= (precision < NW'(3)) ? NW'(3) : (precision > NW'(MAX_W)) ? NW'(MAX_W) : precision;
        es_q <= (es > EW'(MAX_ES)) ? EW'(MAX_ES) : es;
      end
      if (state == IDLE && acc) begin
        cnt   <= NW'(1);
        act_q <= act;
      end else if (state == SHIFT && acc) begin
        cnt <= last ? '0 : cnt_nx;
      end
    end

  // Shared activation decode; subnormals flush to zero.
  logic [EXP_WIDTH-1:0] a_ef;
  logic                 a_zero, a_nar, a_sign;
  logic signed [SW-1:0] a_exp;
  assign a_ef   = act_q[ACT_WIDTH-2 -: EXP_WIDTH];
  assign a_sign = act_q[ACT_WIDTH-1];
  assign a_zero = (a_ef == '0);
  assign a_nar  = (a_ef == '1);
  assign a_exp  = SW'(a_ef) - SW'(BIAS);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fp_posit_mul_vec_lane #(
      .MAN_WIDTH(MAN_WIDTH), .MAX_W(MAX_W), .MAX_ES(MAX_ES),
      .PF(PF), .PW(PW), .SW(SW), .NW(NW), .EW(EW)
    ) u_lane (
      .clk(clk), .rst(rst),
      .shift_en(acc), .first_beat(state == IDLE), .w_bit(w[g]),
      .dec_en(state == DECODE), .mul_en(state == MUL),
      .n(n_q), .es(es_q),
      .a_zero(a_zero), .a_nar(a_nar), .a_sign(a_sign), .a_exp(a_exp),
      .a_frac(act_q[MAN_WIDTH-1:0]),
      .sign_out(sign_out[g]), .exp_out(exp_out[g*SW +: SW]),
      .mant_out(mantissa_out[g*PW +: PW]),
      .zero_out(zero_out[g]), .nar_out(nar_out[g])
    );
  end
endmodule
